// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, stall counting and an
// optional writeback bypass of held operands (enable with `define ID_EX_WB_BYPASS_EN).
module id_ex_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        id_valid_i,
    input  logic [4:0]  id_rs_addr_i,
    input  logic [4:0]  id_rt_addr_i,
    input  logic [4:0]  id_rd_addr_i,
    input  logic [31:0] id_rs_data_i,
    input  logic [31:0] id_rt_data_i,
    input  logic [31:0] id_imm_i,
    input  logic [31:0] id_pc_i,
    input  logic        id_reg_write_i,
    input  logic        id_mem_read_i,
    input  logic        id_mem_write_i,
    input  logic [3:0]  id_alu_op_i,
    input  logic        flush_i,
    input  logic        ex_ready_i,
    input  logic        wb_reg_write_i,
    input  logic [4:0]  wb_rd_addr_i,
    input  logic [31:0] wb_rd_data_i,
    output logic        ex_valid_o,
    output logic [4:0]  ex_rs_addr_o,
    output logic [4:0]  ex_rt_addr_o,
    output logic [4:0]  ex_rd_addr_o,
    output logic [31:0] ex_rs_data_o,
    output logic [31:0] ex_rt_data_o,
    output logic [31:0] ex_imm_o,
    output logic [31:0] ex_pc_o,
    output logic        ex_reg_write_o,
    output logic        ex_mem_read_o,
    output logic        ex_mem_write_o,
    output logic [3:0]  ex_alu_op_o,
    output logic        id_stall_o,
    output logic [15:0] stall_cnt_o
);

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs_addr;
        logic [4:0]  rt_addr;
        logic [4:0]  rd_addr;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [31:0] pc;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic [3:0]  alu_op;
    } ex_bundle_t;

    ex_bundle_t  ex_q, ex_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        load_use;

    // Handshake: the ID instruction moves into EX on an edge where ex_ready_i=1 and
    // it is valid, not flushed and not load-use dependent; ex_ready_i=0 freezes EX,
    // and id_stall_o tells IF/ID to keep presenting the same instruction.
    always_comb begin
        load_use = ex_q.valid & ex_q.mem_read & (ex_q.rd_addr != 5'd0) & id_valid_i &
                   ((ex_q.rd_addr == id_rs_addr_i) | (ex_q.rd_addr == id_rt_addr_i));
        id_stall_o = ~ex_ready_i | load_use;
    end

    always_comb begin
        ex_d        = ex_q;
        stall_cnt_d = stall_cnt_q;
        if (!ex_ready_i) begin
`ifdef ID_EX_WB_BYPASS_EN
            // A held instruction must not miss a result written back while it waits.
            if (ex_q.valid && wb_reg_write_i && (wb_rd_addr_i != 5'd0)) begin
                if (wb_rd_addr_i == ex_q.rs_addr) ex_d.rs_data = wb_rd_data_i;
                if (wb_rd_addr_i == ex_q.rt_addr) ex_d.rt_data = wb_rd_data_i;
            end
`endif
        end else if (load_use || flush_i || !id_valid_i) begin
            ex_d = '0;
        end else begin
            ex_d.valid     = 1'b1;
            ex_d.rs_addr   = id_rs_addr_i;
            ex_d.rt_addr   = id_rt_addr_i;
            ex_d.rd_addr   = id_rd_addr_i;
            ex_d.rs_data   = id_rs_data_i;
            ex_d.rt_data   = id_rt_data_i;
            ex_d.imm       = id_imm_i;
            ex_d.pc        = id_pc_i;
            ex_d.reg_write = id_reg_write_i & (id_rd_addr_i != 5'd0);
            ex_d.mem_read  = id_mem_read_i;
            ex_d.mem_write = id_mem_write_i;
            ex_d.alu_op    = id_alu_op_i;
        end
        if (ex_ready_i && load_use && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

`ifndef ID_EX_WB_BYPASS_EN
    logic unused_wb;
    assign unused_wb = ^{wb_reg_write_i, wb_rd_addr_i, wb_rd_data_i};
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ex_valid_o     = ex_q.valid;
    assign ex_rs_addr_o   = ex_q.rs_addr;
    assign ex_rt_addr_o   = ex_q.rt_addr;
    assign ex_rd_addr_o   = ex_q.rd_addr;
    assign ex_rs_data_o   = ex_q.rs_data;
    assign ex_rt_data_o   = ex_q.rt_data;
    assign ex_imm_o       = ex_q.imm;
    assign ex_pc_o        = ex_q.pc;
    assign ex_reg_write_o = ex_q.reg_write;
    assign ex_mem_read_o  = ex_q.mem_read;
    assign ex_mem_write_o = ex_q.mem_write;
    assign ex_alu_op_o    = ex_q.alu_op;
    assign stall_cnt_o    = stall_cnt_q;

endmodule
